fetch_stage: RTL
================

Name: fetch_stage

Overview:
- IF stage of the pipelined MIPS CPU.
- Owns the PC register and drives the word-addressed PC into the combinational instruction memory.
- Registers the returned instruction into the IF/ID pipeline register for decode.
- Handles stall, flush, branch/jump redirect, and halts on a fetch outside the instruction-memory window.

Parameters:
- RESET_PC, 30'h00100000, word address fetched first after reset.
- IMEM_BASE, 30'h00100000, lowest valid instruction word address.
- IMEM_LAST, 30'h00100100, highest valid instruction word address (inclusive).
- NOP_INST, 32'h00000000, instruction inserted on bubbles (sll $0,$0,0).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hazard unit: hold PC and IF/ID
- flush  in  1  clear IF/ID to bubble
- branch_taken  in  1  EX-stage taken branch
- branch_target  in  30  EX-stage branch word address
- jump_taken  in  1  ID-stage jump
- jump_target  in  30  ID-stage jump word address
- imem_pc  out  30  word address to instruction memory (combinational from PC register)
- imem_inst  in  32  instruction returned combinationally by instruction memory
- id_inst  out  32  IF/ID instruction
- id_pc_plus1  out  30  IF/ID PC+1 (word address)
- id_valid  out  1  IF/ID holds a real instruction
- fault  out  1  sticky: fetch attempted outside [IMEM_BASE, IMEM_LAST]
- halted  out  1  FSM in HALT

Behaviour:
Reset (sync, highest priority):
- pc=RESET_PC, id_inst=NOP_INST, id_pc_plus1=0, id_valid=0, fault=0, state=RUN.
- Reset mid-operation discards any pending redirect, stall, or halt.

Addressing:
- imem_pc=pc at all times.
- pc+1 is computed modulo 2^30; 30'h3FFFFFFF+1 wraps to 0, which is out of range.

FSM states RUN and HALT:
- RUN -> HALT when, in the same cycle, pc is out of range, no redirect is taken, and stall=0. At that edge: fault<=1, IF/ID<=bubble, pc held.
- HALT is exited only by reset.
- In HALT: pc held, IF/ID forced to bubble every cycle, all inputs ignored, halted=1.

Next-PC priority in RUN:
1. branch_taken -> branch_target
2. jump_taken -> jump_target
3. stall -> hold pc
4. otherwise pc+1

Redirect rules:
- Branch beats jump (the branch is the older instruction).
- A redirect overrides stall.
- An out-of-range pc being redirected does not fault; it is a wrong-path fetch.

IF/ID update in RUN, in priority order:
- branch_taken, jump_taken, or flush -> bubble (id_inst=NOP_INST, id_valid=0; id_pc_plus1 keeps its previous value).
- else stall -> hold all IF/ID fields.
- else id_inst<=imem_inst, id_pc_plus1<=pc+1, id_valid<=1.
- flush with stall -> bubble (flush wins).
- Jump-in-ID bubbles the delay slot. There are no architectural delay slots.

Latency:
- The instruction at pc in cycle n appears on id_inst after the edge ending cycle n.
- Redirect target is fetched in cycle n+1 and appears in ID at n+2.

Range check:
- In range means IMEM_BASE <= pc <= IMEM_LAST, unsigned.
- Both boundaries are legal addresses.

Decomposition:
- Shared package mips_pkg holds:
  - NOP_INST and the default RESET_PC/IMEM_BASE/IMEM_LAST constants.
  - The fetch-state enum (FS_RUN, FS_HALT).
  - The IF/ID struct: inst[31:0], pc_plus1[29:0], valid.
- One natural sub-module: next_pc_sel, a purely combinational priority mux producing next pc and the redirect flag.
- The PC register, FSM, and IF/ID register stay in fetch_stage.

Test Plan:
- Reset, then 4 free-run cycles with memory words 0x20080001..0x20080004 -> imem_pc 00100000,00100001,00100002,00100003; id_inst follows one cycle later with id_valid=1; id_pc_plus1=00100001.
- Stall high for 2 cycles at pc=00100002 -> pc and IF/ID (inst, pc_plus1=00100002) frozen; on release pc advances to 00100003.
- branch_taken=1 with target 00100040 and jump_taken=1 with target 00100080 in the same cycle, stall=1 -> next pc=00100040; id_valid=0, id_inst=0 for one cycle; then id_inst=mem[00100040].
- Free-run to IMEM_LAST 00100100 -> that word is fetched with no fault; next cycle pc=00100101 -> fault=1, halted=1, id_valid=0, pc stuck at 00100101 despite branch_taken pulses.
- Jump to 00100101 followed next cycle by branch_taken to 00100010 -> no fault; pc=00100010.
- Reset asserted while in HALT, and separately mid-stall -> next cycle pc=00100000, fault=0, halted=0, id_valid=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and constants: fetch FSM state, IF/ID register layout,
// bubble instruction and default instruction-memory window.
package mips_pkg;

   localparam logic [31:0] NOP_INST      = 32'h0000_0000;
   localparam logic [29:0] DEF_RESET_PC  = 30'h0010_0000;
   localparam logic [29:0] DEF_IMEM_BASE = 30'h0010_0000;
   localparam logic [29:0] DEF_IMEM_LAST = 30'h0010_0100;

   typedef enum logic {
      FS_RUN  = 1'b0,
      FS_HALT = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] inst;
      logic [29:0] pc_plus1;
      logic        valid;
   } ifid_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls in, instruction-memory port, IF/ID outputs.
interface fetch_if;

   logic        stall;
   logic        flush;
   logic        branch_taken;
   logic [29:0] branch_target;
   logic        jump_taken;
   logic [29:0] jump_target;
   logic [29:0] imem_pc;
   logic [31:0] imem_inst;
   logic [31:0] id_inst;
   logic [29:0] id_pc_plus1;
   logic        id_valid;
   logic        fault;
   logic        halted;

   // master is the fetch stage itself
   modport master (
      input  stall, flush, branch_taken, branch_target, jump_taken, jump_target, imem_inst,
      output imem_pc, id_inst, id_pc_plus1, id_valid, fault, halted
   );

   modport slave (
      output stall, flush, branch_taken, branch_target, jump_taken, jump_target, imem_inst,
      input  imem_pc, id_inst, id_pc_plus1, id_valid, fault, halted
   );

endinterface

// File: rtl/fetch_stage_next_pc_sel.sv
// Next-PC priority mux: branch (older) beats jump, any redirect beats stall, else pc+1.
module next_pc_sel (
   input  logic [29:0] pc,
   input  logic [29:0] pc_plus1,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [29:0] branch_target,
   input  logic        jump_taken,
   input  logic [29:0] jump_target,
   output logic [29:0] next_pc,
   output logic        redirect
);

   always_comb begin
      redirect = branch_taken | jump_taken;
      if (branch_taken)    next_pc = branch_target;
      else if (jump_taken) next_pc = jump_target;
      else if (stall)      next_pc = pc;
      else                 next_pc = pc_plus1;
   end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, RUN/HALT fetch FSM and IF/ID pipeline register.
module fetch_stage
   import mips_pkg::*;
#(
   parameter logic [29:0] RESET_PC  = mips_pkg::DEF_RESET_PC,
   parameter logic [29:0] IMEM_BASE = mips_pkg::DEF_IMEM_BASE,
   parameter logic [29:0] IMEM_LAST = mips_pkg::DEF_IMEM_LAST,
   parameter logic [31:0] NOP_INST  = mips_pkg::NOP_INST
) (
   input  logic   clk,
   input  logic   reset,
   fetch_if.master bus
);

   fetch_state_t state, state_n;
   logic [29:0]  pc, pc_n, pc_plus1, sel_pc;
   ifid_t        ifid, ifid_n;
   logic         fault, fault_n;
   logic         redirect, in_range;

   assign pc_plus1 = pc + 30'd1;
   assign in_range = (pc >= IMEM_BASE) && (pc <= IMEM_LAST);

   next_pc_sel u_next_pc_sel (
      .pc            (pc),
      .pc_plus1      (pc_plus1),
      .stall         (bus.stall),
      .branch_taken  (bus.branch_taken),
      .branch_target (bus.branch_target),
      .jump_taken    (bus.jump_taken),
      .jump_target   (bus.jump_target),
      .next_pc       (sel_pc),
      .redirect      (redirect)
   );

   always_comb begin
      state_n = state;
      pc_n    = pc;
      ifid_n  = ifid;
      fault_n = fault;
      case (state)
         FS_RUN: begin
            if (!in_range && !redirect && !bus.stall) begin
               // a redirected or stalled out-of-range pc is a wrong-path fetch, not a fault
               state_n      = FS_HALT;
               fault_n      = 1'b1;
               ifid_n.inst  = NOP_INST;
               ifid_n.valid = 1'b0;
            end else begin
               pc_n = sel_pc;
               if (redirect || bus.flush) begin
                  ifid_n.inst  = NOP_INST;
                  ifid_n.valid = 1'b0;
               end else if (!bus.stall) begin
                  ifid_n.inst     = bus.imem_inst;
                  ifid_n.pc_plus1 = pc_plus1;
                  ifid_n.valid    = 1'b1;
               end
            end
         end
         default: begin
            ifid_n.inst  = NOP_INST;
            ifid_n.valid = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FS_RUN;
         pc    <= RESET_PC;
         ifid  <= '{inst: NOP_INST, pc_plus1: 30'd0, valid: 1'b0};
         fault <= 1'b0;
      end else begin
         state <= state_n;
         pc    <= pc_n;
         ifid  <= ifid_n;
         fault <= fault_n;
      end
   end

   assign bus.imem_pc     = pc;
   assign bus.id_inst     = ifid.inst;
   assign bus.id_pc_plus1 = ifid.pc_plus1;
   assign bus.id_valid    = ifid.valid;
   assign bus.fault       = fault;
   assign bus.halted      = (state == FS_HALT);

endmodule
